counter32b_checker: RTL

//  In-fabric checker that observes the 32-bit mode counter's outputs (Q, RCO, LOAD) and
//  its stimulus (ENABLE, MODO, D), and rebuilds the expected outputs with an internal model.
//  - Flags per-cycle mismatches and keeps a saturating error count.
//  - Captures the first failing expected/observed pair.
//  - Sits beside the counter in the top-level test harness.

---
 rtl/counter32b_checker_pkg.sv | 38 +++
 rtl/counter32b_checker_model.sv | 76 +++++++
 rtl/counter32b_checker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/counter32b_checker_pkg.sv
// -----------------------------------------------------------------------------
// counter32b_checker_pkg
//   Shared definitions for the 32-bit mode-counter checker and its reference
//   model: logic levels, counter mode codes, checker FSM state codes, the bit
//   positions inside the mismatch field vector and a small state-decode helper.
// -----------------------------------------------------------------------------
package counter32b_checker_pkg;

    // Logic levels used by the counter family.
    localparam logic ALTO = 1'b1;
    localparam logic BAJO = 1'b0;

    // Counter modes as applied on MODO.
    typedef enum logic [1:0] {
        CUENTA_MAS_UNO   = 2'b00,  // +1
        CUENTA_MENOS_UNO = 2'b01,  // -1
        CUENTA_TRES_TRES = 2'b10,  // +3
        CARGA_D          = 2'b11   // load D
    } modo_t;

    // Checker FSM states.
    typedef enum logic [1:0] {
        GRACE = 2'b00,  // just out of reset, mismatches ignored
        CHECK = 2'b01,  // comparing, no mismatch seen yet
        FAIL  = 2'b10   // at least one mismatch seen, still comparing
    } chk_state_t;

    // Bit positions inside the {q, rco, load} mismatch vector.
    localparam int ERR_BIT_Q    = 2;
    localparam int ERR_BIT_RCO  = 1;
    localparam int ERR_BIT_LOAD = 0;

    // Comparisons are live in every state except GRACE.
    function automatic logic is_live(input chk_state_t s);
        return (s == CHECK) || (s == FAIL);
    endfunction

endpackage : counter32b_checker_pkg

// File: rtl/counter32b_checker_model.sv
// -----------------------------------------------------------------------------
// counter32b_model
//   Registered reference model of the mode counter. It is clocked on the same
//   edge as the real counter, so its outputs line up cycle-for-cycle with the
//   observed Q/RCO/LOAD.
//
// Ports
//   CLK       in   1      clock, posedge
//   RESET     in   1      synchronous, active-high; clears Q_EXP/RCO_EXP/LOAD_EXP
//   ENABLE    in   1      count/load enable
//   MODO      in   2      00 +1, 01 -1, 10 +3, 11 load D
//   D         in   WIDTH  load value
//   Q_EXP     out  WIDTH  expected counter value
//   RCO_EXP   out  1      expected wrap flag (one cycle)
//   LOAD_EXP  out  1      expected load flag (one cycle)
// -----------------------------------------------------------------------------
module counter32b_model
    import counter32b_checker_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q_EXP,
    output logic             RCO_EXP,
    output logic             LOAD_EXP
);

    // +3 is done one bit wider so the carry out of the MSB is the wrap flag.
    logic [WIDTH:0] sum_tres;
    logic           q_all_ones;
    logic           q_all_zero;

    assign sum_tres   = {1'b0, Q_EXP} + (WIDTH + 1)'(3);
    assign q_all_ones = &Q_EXP;
    assign q_all_zero = ~|Q_EXP;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q_EXP    <= '0;
            RCO_EXP  <= BAJO;
            LOAD_EXP <= BAJO;
        end else if (!ENABLE) begin
            // Hold the count; both flags are single-cycle so they drop.
            RCO_EXP  <= BAJO;
            LOAD_EXP <= BAJO;
        end else begin
            case (MODO)
                CUENTA_MAS_UNO: begin
                    Q_EXP    <= Q_EXP + WIDTH'(1);
                    RCO_EXP  <= q_all_ones;
                    LOAD_EXP <= BAJO;
                end
                CUENTA_MENOS_UNO: begin
                    Q_EXP    <= Q_EXP - WIDTH'(1);
                    RCO_EXP  <= q_all_zero;
                    LOAD_EXP <= BAJO;
                end
                CUENTA_TRES_TRES: begin
                    Q_EXP    <= sum_tres[WIDTH-1:0];
                    RCO_EXP  <= sum_tres[WIDTH];
                    LOAD_EXP <= BAJO;
                end
                default: begin  // CARGA_D
                    Q_EXP    <= D;
                    RCO_EXP  <= BAJO;
                    LOAD_EXP <= ALTO;
                end
            endcase
        end
    end

endmodule : counter32b_model

// File: rtl/counter32b_checker.sv
// -----------------------------------------------------------------------------
// counter32b_checker
//   In-fabric checker for the 32-bit mode counter. It replays the counter's
//   stimulus into a reference model, compares the model against the observed
//   counter outputs every cycle, and reports mismatches with a one-cycle pulse,
//   a per-field vector, a sticky error flag, a saturating error count and a
//   capture of the first failing expected/observed Q pair.
//
//   Timing: the model and the counter update on the same edge, so cycle n's
//   observed outputs are compared combinationally against the model value
//   registered in cycle n. The result is registered, so ERR_PULSE/ERR_FIELDS
//   describe cycle n during cycle n+1.
//
// Ports
//   CLK          in   1          clock, posedge
//   RESET        in   1          synchronous, active-high
//   ENABLE       in   1          counter stimulus
//   MODO         in   2          counter mode (00 +1, 01 -1, 10 +3, 11 load)
//   D            in   WIDTH      counter load value
//   Q            in   WIDTH      observed counter value
//   RCO          in   1          observed wrap flag
//   LOAD         in   1          observed load flag
//   CHECKING     out  1          high in CHECK or FAIL
//   ERR_PULSE    out  1          mismatch seen in the previous cycle
//   ERR_FIELDS   out  3          {q, rco, load} mismatch bits, zero without ERR_PULSE
//   ERROR        out  1          sticky mismatch flag, cleared by RESET only
//   ERR_COUNT    out  ERR_CNT_W  mismatching cycles, saturating
//   FAIL_EXP_Q   out  WIDTH      model Q at the first mismatch
//   FAIL_OBS_Q   out  WIDTH      observed Q at the first mismatch
//   DBG_STATE    out  2          current FSM state (chk_state_t encoding)
// -----------------------------------------------------------------------------
module counter32b_checker
    import counter32b_checker_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int GRACE_CYCLES = 2,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [1:0]           MODO,
    input  logic [WIDTH-1:0]     D,
    input  logic [WIDTH-1:0]     Q,
    input  logic                 RCO,
    input  logic                 LOAD,
    output logic                 CHECKING,
    output logic                 ERR_PULSE,
    output logic [2:0]           ERR_FIELDS,
    output logic                 ERROR,
    output logic [ERR_CNT_W-1:0] ERR_COUNT,
    output logic [WIDTH-1:0]     FAIL_EXP_Q,
    output logic [WIDTH-1:0]     FAIL_OBS_Q,
    output logic [1:0]           DBG_STATE
);

    // Grace counter needs at least one bit even when GRACE_CYCLES is 0.
    localparam int GRACE_W = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;
    localparam logic [GRACE_W-1:0] GRACE_INIT = GRACE_W'(GRACE_CYCLES);

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] q_exp;
    logic             rco_exp;
    logic             load_exp;

    counter32b_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .MODO     (MODO),
        .D        (D),
        .Q_EXP    (q_exp),
        .RCO_EXP  (rco_exp),
        .LOAD_EXP (load_exp)
    );

    // -------------------------------------------------------------------------
    // Combinational compare
    // -------------------------------------------------------------------------
    chk_state_t   state;
    logic [GRACE_W-1:0] grace_cnt;
    logic [2:0]   mism;
    logic         any_mism;
    logic         live;
    logic         hit;

    always_comb begin
        mism               = 3'b000;
        mism[ERR_BIT_Q]    = (Q    != q_exp);
        mism[ERR_BIT_RCO]  = (RCO  != rco_exp);
        mism[ERR_BIT_LOAD] = (LOAD != load_exp);
    end

    assign any_mism = |mism;
    assign live     = is_live(state);
    // A mismatch only counts once the checker has left GRACE.
    assign hit      = live && any_mism;

    // -------------------------------------------------------------------------
    // FSM, flags, error counter and first-failure capture
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // Reset wins over any mismatch present in the same cycle.
            state      <= GRACE;
            grace_cnt  <= GRACE_INIT;
            CHECKING   <= BAJO;
            ERR_PULSE  <= BAJO;
            ERR_FIELDS <= 3'b000;
            ERROR      <= BAJO;
            ERR_COUNT  <= '0;
            FAIL_EXP_Q <= '0;
            FAIL_OBS_Q <= '0;
        end else begin
            ERR_PULSE  <= hit;
            ERR_FIELDS <= hit ? mism : 3'b000;

            if (hit) begin
                ERROR <= ALTO;
                // One count per mismatching cycle, held at all-ones.
                if (ERR_COUNT != '1) begin
                    ERR_COUNT <= ERR_COUNT + ERR_CNT_W'(1);
                end
            end

            case (state)
                GRACE: begin
                    if (grace_cnt == '0) begin
                        state    <= CHECK;
                        CHECKING <= ALTO;
                    end else begin
                        grace_cnt <= grace_cnt - GRACE_W'(1);
                    end
                end
                CHECK: begin
                    CHECKING <= ALTO;
                    if (any_mism) begin
                        // Capture happens only on this transition, so later
                        // mismatches in FAIL leave the first pair intact.
                        state      <= FAIL;
                        FAIL_EXP_Q <= q_exp;
                        FAIL_OBS_Q <= Q;
                    end
                end
                FAIL: begin
                    CHECKING <= ALTO;
                end
                default: begin
                    state    <= GRACE;
                    CHECKING <= BAJO;
                end
            endcase
        end
    end

    assign DBG_STATE = state;

endmodule : counter32b_checker
